// File: rtl/mem_controller_pkg.sv
// Shared types for the cache-line memory controller:
// word/line geometry, FSM states and grant encoding.
package mem_controller_pkg;

  localparam int WORD_SIZE  = 16;
  localparam int LINE_WORDS = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_controller_if.sv
// Cache-side request ports and word-wide memory bus.
// master = controller, slave = caches plus memory.
interface mem_controller_if #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4
);

  localparam int LW = WORD_SIZE * LINE_WORDS;

  logic                 i_req;
  logic [WORD_SIZE-1:0] i_addr;
  logic [LW-1:0]        i_line;
  logic                 i_done;

  logic                 d_req;
  logic                 d_we;
  logic [WORD_SIZE-1:0] d_addr;
  logic [LW-1:0]        d_wline;
  logic [LW-1:0]        d_line;
  logic                 d_done;

  logic                 mem_read;
  logic                 mem_write;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic                 mem_ack;

  modport master (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wline,
    input  mem_rdata, mem_ack,
    output i_line, i_done,
    output d_line, d_done,
    output mem_read, mem_write,
    output mem_addr, mem_wdata
  );

  modport slave (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wline,
    output mem_rdata, mem_ack,
    input  i_line, i_done,
    input  d_line, d_done,
    input  mem_read, mem_write,
    input  mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_rr.sv
// Two-way I/D arbiter; ties alternate, starting with D.
// The pointer only moves when a tie is actually granted.
module mem_arbiter_rr
  import mem_controller_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   i_req,
  input  logic   d_req,
  input  logic   update,
  output grant_t grant
);

  grant_t prio;

  always_comb begin
    grant = prio;
    unique case (1'b1)
      (i_req & ~d_req): grant = GNT_I;
      (d_req & ~i_req): grant = GNT_D;
      default:          grant = prio;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      prio <= GNT_D;
    end else if (update && i_req && d_req) begin
      prio <= (grant == GNT_D) ? GNT_I : GNT_D;
    end
  end

endmodule

// File: rtl/mem_controller.sv
// Serialises I/D cache line refills and D writebacks
// into word transfers on a single ack-driven memory bus.
module mem_controller #(
  parameter int WORD_SIZE  = mem_controller_pkg::WORD_SIZE,
  parameter int LINE_WORDS = mem_controller_pkg::LINE_WORDS
) (
  input logic              clk,
  input logic              reset_n,
  mem_controller_if.master bus
);

  import mem_controller_pkg::*;

  localparam int LW = WORD_SIZE * LINE_WORDS;
  localparam int KW =
    (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  state_t               state;
  grant_t               grant;
  grant_t               gnt_q;
  logic                 we_q;
  logic [KW-1:0]        k;
  logic [LW-1:0]        wline_q;
  logic [LW-1:0]        buf_q;
  logic [LW-1:0]        buf_nx;
  logic [WORD_SIZE-1:0] sel_addr;
  logic [WORD_SIZE-1:0] line_base;
  logic                 sel_we;
  logic                 any_req;
  logic                 upd;
  logic                 last;

  assign any_req = bus.i_req | bus.d_req;
  assign upd     = (state == S_IDLE) && any_req;
  assign last    = (k == KW'(LINE_WORDS - 1));

  assign sel_addr  = (grant == GNT_I) ? bus.i_addr
                                      : bus.d_addr;
  assign line_base = sel_addr
                   & ~WORD_SIZE'(LINE_WORDS - 1);
  assign sel_we    = (grant == GNT_D) && bus.d_we;

  mem_arbiter_rr u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .i_req   (bus.i_req),
    .d_req   (bus.d_req),
    .update  (upd),
    .grant   (grant)
  );

  // Refill data lands in a staging line so the visible
  // line only changes when the whole refill completes.
  always_comb begin
    buf_nx = buf_q;
    buf_nx[int'(k)*WORD_SIZE +: WORD_SIZE] =
      bus.mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state         <= S_IDLE;
      gnt_q         <= GNT_I;
      we_q          <= 1'b0;
      k             <= '0;
      wline_q       <= '0;
      buf_q         <= '0;
      bus.i_line    <= '0;
      bus.i_done    <= 1'b0;
      bus.d_line    <= '0;
      bus.d_done    <= 1'b0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.i_done <= 1'b0;
      bus.d_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            state         <= S_XFER;
            gnt_q         <= grant;
            we_q          <= sel_we;
            k             <= '0;
            wline_q       <= bus.d_wline >> WORD_SIZE;
            bus.mem_addr  <= line_base;
            bus.mem_read  <= ~sel_we;
            bus.mem_write <= sel_we;
            bus.mem_wdata <= sel_we
              ? bus.d_wline[WORD_SIZE-1:0] : '0;
          end
        end
        S_XFER: begin
          if (bus.mem_ack) begin
            if (!we_q) buf_q <= buf_nx;
            if (last) begin
              state         <= S_DONE;
              bus.mem_read  <= 1'b0;
              bus.mem_write <= 1'b0;
              bus.mem_addr  <= '0;
              bus.mem_wdata <= '0;
              if (gnt_q == GNT_I) begin
                bus.i_line <= buf_nx;
                bus.i_done <= 1'b1;
              end else begin
                if (!we_q) bus.d_line <= buf_nx;
                bus.d_done <= 1'b1;
              end
            end else begin
              k             <= k + KW'(1);
              bus.mem_addr  <= bus.mem_addr
                             + WORD_SIZE'(1);
              wline_q       <= wline_q >> WORD_SIZE;
              bus.mem_wdata <= we_q
                ? wline_q[WORD_SIZE-1:0] : '0;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
